// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - host byte bus, stored operands and result bundle for matrix_loader
interface matrix_loader_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 2,
    parameter int RES_W   = 17
);
    logic [DATA_W-1:0]                  data_send;
    logic [1:0]                         ctrl_logic;
    logic [DATA_W-1:0]                  r1;
    logic [DATA_W-1:0]                  c1;
    logic [DATA_W-1:0]                  r2;
    logic [DATA_W-1:0]                  c2;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  mat1;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  mat2;
    logic [MAX_DIM*MAX_DIM*RES_W-1:0]   result;
    logic                               result_valid;
    logic                               dim_error;

    modport master (
        output data_send, ctrl_logic,
        input  r1, c1, r2, c2, mat1, mat2, result, result_valid, dim_error
    );

    modport slave (
        input  data_send, ctrl_logic,
        output r1, c1, r2, c2, mat1, mat2, result, result_valid, dim_error
    );
endinterface

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - byte-serial loader for two operand matrices with registered multiply on EXEC
module matrix_loader #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 2,
    parameter int RES_W   = 17
) (
    input  logic           CLK,
    input  logic           RST,
    matrix_loader_if.slave bus
);
    localparam int NN    = MAX_DIM * MAX_DIM;
    localparam int PTR_W = $clog2(2 * NN + 1);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [1:0] CTRL_DATA = 2'd0;
    localparam logic [1:0] CTRL_SIZE = 2'd1;
    localparam logic [1:0] CTRL_EXEC = 2'd2;

    localparam logic [2:0]        SIZE_FULL = 3'd4;
    localparam logic [PTR_W-1:0]  DATA_FULL = PTR_W'(2 * NN);
    localparam logic [PTR_W-1:0]  MAT2_BASE = PTR_W'(NN);
    localparam logic [DATA_W-1:0] DIM_MAX   = DATA_W'(MAX_DIM);

    // dims[0..3] = R1, C1, R2, C2
    logic [DATA_W-1:0] dims [4];
    logic [2:0]        size_ptr;
    logic [PTR_W-1:0]  data_ptr;
    logic [DATA_W-1:0] m1 [NN];
    logic [DATA_W-1:0] m2 [NN];
    logic [RES_W-1:0]  res_q [NN];
    logic [RES_W-1:0]  prod [NN];
    logic              result_valid_q;
    logic              dim_error_q;
    logic              dims_ok;
    logic              load_full;
    logic [IDX_W-1:0]  m1_idx;
    logic [IDX_W-1:0]  m2_idx;

    assign m1_idx    = IDX_W'(data_ptr);
    assign m2_idx    = IDX_W'(data_ptr - MAT2_BASE);
    assign load_full = (size_ptr == SIZE_FULL) && (data_ptr == DATA_FULL);

    always_comb begin
        dims_ok = (dims[1] == dims[2]);
        for (int d = 0; d < 4; d++) begin
            if (dims[d] == '0 || dims[d] > DIM_MAX) begin
                dims_ok = 1'b0;
            end
        end
    end

    // Storage is always N-wide; terms outside the captured dimensions are masked off.
    always_comb begin
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
                prod[i*MAX_DIM+j] = '0;
                for (int k = 0; k < MAX_DIM; k++) begin
                    if (i < int'(dims[0]) && j < int'(dims[3]) && k < int'(dims[1])) begin
                        prod[i*MAX_DIM+j] = prod[i*MAX_DIM+j]
                            + RES_W'(m1[i*MAX_DIM+k]) * RES_W'(m2[k*MAX_DIM+j]);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int d = 0; d < 4; d++) dims[d] <= '0;
            for (int e = 0; e < NN; e++) begin
                m1[e]    <= '0;
                m2[e]    <= '0;
                res_q[e] <= '0;
            end
            size_ptr       <= '0;
            data_ptr       <= '0;
            result_valid_q <= 1'b0;
            dim_error_q    <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (bus.ctrl_logic)
                CTRL_SIZE: begin
                    if (size_ptr < SIZE_FULL) begin
                        dims[size_ptr[1:0]] <= bus.data_send;
                        size_ptr            <= size_ptr + 3'd1;
                    end
                end
                CTRL_DATA: begin
                    if (data_ptr < DATA_FULL) begin
                        if (data_ptr < MAT2_BASE) m1[m1_idx] <= bus.data_send;
                        else                      m2[m2_idx] <= bus.data_send;
                        data_ptr <= data_ptr + PTR_W'(1);
                    end
                end
                CTRL_EXEC: begin
                    size_ptr <= '0;
                    data_ptr <= '0;
                    if (load_full) begin
                        result_valid_q <= 1'b1;
                        dim_error_q    <= ~dims_ok;
                        for (int e = 0; e < NN; e++) begin
                            res_q[e] <= dims_ok ? prod[e] : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.r1           = dims[0];
    assign bus.c1           = dims[1];
    assign bus.r2           = dims[2];
    assign bus.c2           = dims[3];
    assign bus.result_valid = result_valid_q;
    assign bus.dim_error    = dim_error_q;

    for (genvar g = 0; g < NN; g++) begin : g_pack
        assign bus.mat1[g*DATA_W +: DATA_W]  = m1[g];
        assign bus.mat2[g*DATA_W +: DATA_W]  = m2[g];
        assign bus.result[g*RES_W +: RES_W]  = res_q[g];
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader load, multiply and reset behaviour
module tb_matrix_loader;
    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 2;
    localparam int RES_W   = 17;
    localparam int NN      = MAX_DIM * MAX_DIM;

    localparam logic [1:0] C_DATA = 2'd0;
    localparam logic [1:0] C_SIZE = 2'd1;
    localparam logic [1:0] C_EXEC = 2'd2;
    localparam logic [1:0] C_IDLE = 2'd3;

    typedef struct {
        logic                  err;
        logic [NN*RES_W-1:0]   res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int md[4];
    int me[2*NN];
    int sptr = 0;
    int dptr = 0;

    matrix_loader_if #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .RES_W(RES_W)) bus ();

    matrix_loader #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .RES_W(RES_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit model_ok();
        bit ok = (md[1] == md[2]);
        for (int d = 0; d < 4; d++) if (md[d] < 1 || md[d] > MAX_DIM) ok = 0;
        return ok;
    endfunction

    function automatic logic [NN*RES_W-1:0] model_product();
        logic [NN*RES_W-1:0] r = '0;
        int s;
        for (int i = 0; i < md[0]; i++) begin
            for (int j = 0; j < md[3]; j++) begin
                s = 0;
                for (int k = 0; k < md[1]; k++) s += me[i*MAX_DIM+k] * me[NN+k*MAX_DIM+j];
                r[(i*MAX_DIM+j)*RES_W +: RES_W] = s[RES_W-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [NN*DATA_W-1:0] model_mat(input int which);
        logic [NN*DATA_W-1:0] m = '0;
        int v;
        for (int e = 0; e < NN; e++) begin
            v = me[which*NN+e];
            m[e*DATA_W +: DATA_W] = v[DATA_W-1:0];
        end
        return m;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 4; d++) md[d] = 0;
        for (int e = 0; e < 2*NN; e++) me[e] = 0;
        sptr = 0;
        dptr = 0;
        sb.delete();
    endtask

    task automatic send(input logic [1:0] c, input int d);
        exp_t e;
        bus.ctrl_logic = c;
        bus.data_send  = d[DATA_W-1:0];
        case (c)
            C_SIZE: if (sptr < 4) begin md[sptr] = d; sptr++; end
            C_DATA: if (dptr < 2*NN) begin me[dptr] = d; dptr++; end
            C_EXEC: begin
                if (sptr == 4 && dptr == 2*NN) begin
                    e.err = !model_ok();
                    e.res = e.err ? '0 : model_product();
                    sb.push_back(e);
                end
                sptr = 0;
                dptr = 0;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        if (c != C_EXEC) begin
            checks++;
            if (bus.result_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_idle: got %b required 0 after ctrl %0d", bus.result_valid, c);
            end
        end
    endtask

    task automatic do_reset(input int cycles, input logic [1:0] ctrl);
        rst            = 1'b1;
        bus.ctrl_logic = ctrl;
        bus.data_send  = 8'hA5;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.ctrl_logic = C_IDLE;
        model_clear();
        checks++;
        if ({bus.r1, bus.c1, bus.r2, bus.c2} !== '0) begin
            errors++;
            $display("FAIL reset_dims: got %h required 0", {bus.r1, bus.c1, bus.r2, bus.c2});
        end
        checks++;
        if ({bus.mat1, bus.mat2} !== '0) begin
            errors++;
            $display("FAIL reset_mats: got %h required 0", {bus.mat1, bus.mat2});
        end
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h required 0", bus.result);
        end
        checks++;
        if ({bus.result_valid, bus.dim_error} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00", {bus.result_valid, bus.dim_error});
        end
    endtask

    task automatic load_block(input int dm[4], input int el[2*NN], input int xs, input int xd);
        for (int d = 0; d < 4; d++) send(C_SIZE, dm[d]);
        for (int x = 0; x < xs; x++) send(C_SIZE, $urandom_range(0, 255));
        for (int e = 0; e < 2*NN; e++) send(C_DATA, el[e]);
        for (int x = 0; x < xd; x++) send(C_DATA, $urandom_range(0, 255));
        checks++;
        if ({bus.r1, bus.c1, bus.r2, bus.c2} !==
            {DATA_W'(md[0]), DATA_W'(md[1]), DATA_W'(md[2]), DATA_W'(md[3])}) begin
            errors++;
            $display("FAIL dims: got %h required %h", {bus.r1, bus.c1, bus.r2, bus.c2},
                     {DATA_W'(md[0]), DATA_W'(md[1]), DATA_W'(md[2]), DATA_W'(md[3])});
        end
        checks++;
        if ({bus.mat2, bus.mat1} !== {model_mat(1), model_mat(0)}) begin
            errors++;
            $display("FAIL mats: got %h required %h", {bus.mat2, bus.mat1}, {model_mat(1), model_mat(0)});
        end
    endtask

    task automatic exec_and_check(input string name);
        exp_t e;
        send(C_EXEC, 0);
        checks++;
        if (sb.size() == 0) begin
            if (bus.result_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_novalid: got %b required 0", name, bus.result_valid);
            end
        end else begin
            e = sb.pop_front();
            if (bus.result_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid: got %b required 1", name, bus.result_valid);
            end
            checks++;
            if (bus.result !== e.res) begin
                errors++;
                $display("FAIL %s_result: got %h required %h", name, bus.result, e.res);
            end
            checks++;
            if (bus.dim_error !== e.err) begin
                errors++;
                $display("FAIL %s_dim_error: got %b required %b", name, bus.dim_error, e.err);
            end
        end
    endtask

    task automatic test_reset();
        do_reset(2, C_IDLE);
    endtask

    task automatic test_basic();
        int dm[4];
        int el[2*NN];
        dm = '{2, 2, 2, 2};
        el = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_block(dm, el, 0, 0);
        checks++;
        if ({bus.mat2, bus.mat1} !== 64'h08070605_04030201) begin
            errors++;
            $display("FAIL basic_mats: got %h required 0807060504030201", {bus.mat2, bus.mat1});
        end
        exec_and_check("basic");
        checks++;
        if (bus.result !== {17'd50, 17'd43, 17'd22, 17'd19}) begin
            errors++;
            $display("FAIL basic_const: got %h required %h", bus.result, {17'd50, 17'd43, 17'd22, 17'd19});
        end
        send(C_IDLE, 0);
        checks++;
        if (bus.result !== {17'd50, 17'd43, 17'd22, 17'd19}) begin
            errors++;
            $display("FAIL basic_hold: got %h required %h", bus.result, {17'd50, 17'd43, 17'd22, 17'd19});
        end
    endtask

    task automatic test_overflow();
        int dm[4];
        int el[2*NN];
        dm = '{2, 2, 2, 2};
        for (int e = 0; e < 2*NN; e++) el[e] = 255;
        load_block(dm, el, 0, 0);
        exec_and_check("overflow");
        checks++;
        if (bus.result !== {4{17'd130050}}) begin
            errors++;
            $display("FAIL overflow_const: got %h required %h", bus.result, {4{17'd130050}});
        end
        send(C_IDLE, 0);
    endtask

    task automatic test_mismatch();
        int dm[4];
        int el[2*NN];
        dm = '{2, 1, 2, 2};
        for (int e = 0; e < 2*NN; e++) el[e] = e + 3;
        load_block(dm, el, 0, 0);
        exec_and_check("mismatch");
        checks++;
        if ({bus.dim_error, bus.result} !== {1'b1, {(NN*RES_W){1'b0}}}) begin
            errors++;
            $display("FAIL mismatch_const: got err=%b res=%h required err=1 res=0", bus.dim_error, bus.result);
        end
        send(C_IDLE, 0);
    endtask

    task automatic test_incomplete();
        int dm[4];
        int el[2*NN];
        for (int d = 0; d < 4; d++) send(C_SIZE, 2);
        for (int e = 0; e < 5; e++) send(C_DATA, e + 9);
        exec_and_check("incomplete");
        dm = '{2, 2, 2, 1};
        for (int e = 0; e < 2*NN; e++) el[e] = $urandom_range(0, 255);
        load_block(dm, el, 0, 0);
        exec_and_check("after_incomplete");
        send(C_IDLE, 0);
    endtask

    task automatic test_reset_mid();
        int dm[4];
        int el[2*NN];
        for (int d = 0; d < 4; d++) send(C_SIZE, 2);
        for (int e = 0; e < 3; e++) send(C_DATA, e + 40);
        do_reset(1, C_DATA);
        dm = '{1, 2, 2, 2};
        for (int e = 0; e < 2*NN; e++) el[e] = $urandom_range(0, 255);
        load_block(dm, el, 0, 0);
        exec_and_check("after_reset");
        send(C_IDLE, 0);
    endtask

    task automatic test_back_to_back();
        int dm[4];
        int el[2*NN];
        for (int b = 0; b < 8; b++) begin
            for (int d = 0; d < 4; d++) dm[d] = $urandom_range(1, MAX_DIM);
            if (b % 3 == 0) dm[2] = dm[1];
            for (int e = 0; e < 2*NN; e++) el[e] = $urandom_range(0, 255);
            load_block(dm, el, (b == 3) ? 2 : 0, (b == 3) ? 3 : 0);
            exec_and_check($sformatf("b2b%0d", b));
        end
        send(C_IDLE, 0);
    endtask

    initial begin
        bus.ctrl_logic = C_IDLE;
        bus.data_send  = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_mismatch();
        test_incomplete();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Byte-serial matrix loader and multiplier.
- A host streams dimension bytes and then element bytes on an 8-bit bus, qualified by a 2-bit control code.
- The block holds two operand matrices of up to MAX_DIM x MAX_DIM, then multiplies them on command and presents a registered result with a valid pulse.
- It sits between the host byte interface and downstream result consumers in the matrix-multiply datapath.

Parameters:
- DATA_W, 8: width of the data bus, each dimension register and each matrix element (unsigned).
- MAX_DIM, 2: maximum rows/columns per matrix. Each matrix stores MAX_DIM*MAX_DIM elements.
- RES_W, 17: result element width. Must be >= 2*DATA_W + clog2(MAX_DIM).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- data_send  in  DATA_W  byte from host, sampled every rising edge.
- ctrl_logic  in  2  command code: 0 = DATA, 1 = SIZE, 2 = EXEC, 3 = IDLE.
- r1, c1, r2, c2  out  DATA_W each  captured dimensions of matrix_1 (R1xC1) and matrix_2 (R2xC2).
- mat1, mat2  out  MAX_DIM*MAX_DIM*DATA_W  stored operands, row-major, element 0 in LSBs.
- result  out  MAX_DIM*MAX_DIM*RES_W  product matrix, row-major, element 0 in LSBs.
- result_valid  out  1  one-cycle pulse when result/dim_error update.
- dim_error  out  1  dimension check of the last EXEC failed; held until next EXEC or reset.

Behaviour:
- Reset (RST=1 at an edge): clear all dimension registers, matrices, result, size_ptr, data_ptr, result_valid and dim_error to 0. Reset overrides ctrl_logic in the same cycle, including mid-load.
- SIZE (ctrl=1):
  - data_send is written to slot size_ptr (0=R1, 1=C1, 2=R2, 3=C2), then size_ptr increments.
  - After 4 writes size_ptr saturates at 4; further SIZE bytes are ignored.
- DATA (ctrl=0):
  - data_send is written to element data_ptr, then data_ptr increments.
  - Elements 0..N*N-1 (N = MAX_DIM) fill mat1 row-major; elements N*N..2*N*N-1 fill mat2 row-major.
  - data_ptr saturates at 2*N*N; extra bytes are ignored.
  - Fixed N-wide storage layout is used regardless of the captured dimensions.
- EXEC (ctrl=2):
  - size_ptr and data_ptr clear to 0, ready for the next load.
  - If size_ptr==4 and data_ptr==2*N*N at this edge, a multiply is performed; otherwise EXEC only clears pointers (no result_valid).
  - Consecutive EXEC cycles: only the first may multiply, because the pointers are already cleared.
- Multiply:
  - Check: R1, C1, R2, C2 all in 1..MAX_DIM and C1==R2.
  - On failure: result <= 0, dim_error <= 1.
  - On pass: result[i][j] = sum over k<C1 of mat1[i][k]*mat2[k][j] for i<R1, j<C2, unsigned, full width. Elements outside R1xC2 are 0. dim_error <= 0.
  - result and dim_error are registered at the EXEC edge. result_valid is 1 for exactly the cycle following that edge.
- IDLE (ctrl=3): no state change.
- Storage persistence: dimension and matrix registers hold their values across EXEC. A new load overwrites them slot by slot.
- result_valid is 0 whenever no multiply occurred on the previous edge.

Test Plan:
- Basic load and multiply:
  - Stimulus: RST 2 cycles; SIZE 2,2,2,2; DATA 1,2,3,4,5,6,7,8; EXEC.
  - Required: r1=c1=r2=c2=2, mat1={1,2,3,4}, mat2={5,6,7,8}; next cycle result={19,22,43,50}, result_valid=1 for one cycle, dim_error=0.
- Max-value overflow:
  - Stimulus: all elements 255, 2x2 dims.
  - Required: every result element = 130050, no truncation.
- Dimension mismatch:
  - Stimulus: SIZE 2,1,2,2; 8 DATA bytes; EXEC.
  - Required: result_valid pulse, dim_error=1, result all 0.
- Incomplete load:
  - Stimulus: SIZE x4, 5 DATA bytes, EXEC.
  - Required: no result_valid; pointers cleared; a following full load+EXEC multiplies correctly.
- Reset mid-load:
  - Stimulus: RST asserted after 3 DATA bytes.
  - Required: all outputs 0 next cycle; a fresh full sequence gives the correct product.
- Back-to-back blocks:
  - Stimulus: 8 consecutive sequences of SIZE x4, DATA x8, EXEC with random bytes, plus 2 extra SIZE and 3 extra DATA bytes in one block.
  - Required: each EXEC yields the reference product; extra bytes are ignored.
